// File: rtl/ame_num_pkg.sv
// Shared definitions for the AME log-domain number blocks (approx/expand).
package ame_num_pkg;

  typedef enum logic {
    SHIFT_RIGHT = 1'b0,
    SHIFT_LEFT  = 1'b1
  } shift_dir_t;

  function automatic int exp_bits(input int data_bits);
    return $clog2(data_bits);
  endfunction

  localparam int DEF_COMP_DATA_BITS = 64;
  localparam int EXP_BITS           = exp_bits(DEF_COMP_DATA_BITS);

endpackage

// File: rtl/ame_num_shift.sv
// Combinational bidirectional logical barrel shifter; right shifts truncate.
module ame_num_shift
  import ame_num_pkg::*;
#(
  parameter int DATA_BITS = 64,
  parameter int AMT_BITS  = 6
) (
  input  logic [DATA_BITS-1:0] data,
  input  logic [AMT_BITS-1:0]  amount,
  input  shift_dir_t           dir,
  output logic [DATA_BITS-1:0] result
);

  always_comb begin
    result = '0;
    if (dir == SHIFT_LEFT) begin
      result = data << amount;
    end else begin
      result = data >> amount;
    end
  end

endmodule

// File: rtl/ame_num_expand.sv
// Mitchell antilog: expands a log-domain code (e, f) to 2^e + ((f*2^e) >> FRAC_BITS).
// Three register stages, one code per clock, comp_done_o is comp_init_i delayed by 3.
module ame_num_expand
  import ame_num_pkg::*;
#(
  parameter int COMP_DATA_BITS = 64,
  parameter int FRAC_BITS      = 4,
  localparam int EW            = exp_bits(COMP_DATA_BITS)
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      comp_init_i,
  input  logic                      comp_zero_i,
  input  logic [EW-1:0]             comp_data_i,
  input  logic [FRAC_BITS-1:0]      comp_frac_i,
  output logic                      comp_done_o,
  output logic [COMP_DATA_BITS-1:0] comp_data_o
);

  localparam logic [EW-1:0] FRAC_E = EW'(FRAC_BITS);

  logic                 v0;
  logic                 z0;
  logic [EW-1:0]        e0;
  logic [FRAC_BITS-1:0] f0;

  logic                 v1;
  logic                 z1;
  logic [FRAC_BITS:0]   m1;
  logic [EW-1:0]        sh1;
  shift_dir_t           dir1;

  logic [COMP_DATA_BITS-1:0] shifted;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      v0 <= 1'b0;
      z0 <= 1'b0;
      e0 <= '0;
      f0 <= '0;
    end else begin
      v0 <= comp_init_i;
      if (comp_init_i) begin
        z0 <= comp_zero_i;
        e0 <= comp_data_i;
        f0 <= comp_frac_i;
      end
    end
  end

  // Exponent relative to the binary point of {1,f} picks direction and distance.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      v1   <= 1'b0;
      z1   <= 1'b0;
      m1   <= '0;
      sh1  <= '0;
      dir1 <= SHIFT_RIGHT;
    end else begin
      v1 <= v0;
      if (v0) begin
        z1 <= z0;
        m1 <= {1'b1, f0};
        if (e0 >= FRAC_E) begin
          dir1 <= SHIFT_LEFT;
          sh1  <= e0 - FRAC_E;
        end else begin
          dir1 <= SHIFT_RIGHT;
          sh1  <= FRAC_E - e0;
        end
      end
    end
  end

  ame_num_shift #(
    .DATA_BITS (COMP_DATA_BITS),
    .AMT_BITS  (EW)
  ) u_shift (
    .data   (COMP_DATA_BITS'(m1)),
    .amount (sh1),
    .dir    (dir1),
    .result (shifted)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      comp_done_o <= 1'b0;
      comp_data_o <= '0;
    end else begin
      comp_done_o <= v1;
      if (v1) begin
        comp_data_o <= z1 ? '0 : shifted;
      end
    end
  end

endmodule

// File: tb/tb_ame_num_expand.sv
// Self-checking bench for ame_num_expand: Mitchell-antilog reference model plus directed literals.
module tb_ame_num_expand;

  localparam int CDB = 64;
  localparam int FB  = 4;
  localparam int EW  = $clog2(CDB);

  logic           clk_i = 1'b0;
  logic           rst_n_i = 1'b0;
  logic           comp_init_i = 1'b0;
  logic           comp_zero_i = 1'b0;
  logic [EW-1:0]  comp_data_i = '0;
  logic [FB-1:0]  comp_frac_i = '0;
  logic           comp_done_o;
  logic [CDB-1:0] comp_data_o;

  int n_cmp  = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  ame_num_expand #(.COMP_DATA_BITS(CDB), .FRAC_BITS(FB)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .comp_init_i (comp_init_i),
    .comp_zero_i (comp_zero_i),
    .comp_data_i (comp_data_i),
    .comp_frac_i (comp_frac_i),
    .comp_done_o (comp_done_o),
    .comp_data_o (comp_data_o)
  );

  always #5 clk_i = ~clk_i;

  // Antilog evaluated in wide integer arithmetic straight from the formula.
  function automatic logic [CDB-1:0] ref_val(input int e, input int f, input bit z);
    logic [127:0] p;
    if (z) return '0;
    p = (128'd1 << e) + ((128'(f) << e) >> FB);
    return p[CDB-1:0];
  endfunction

  // Model: codes age through a delay line; the output value holds when nothing emerges.
  logic           hv0, hv1;
  logic [CDB-1:0] hd0, hd1;
  logic           exp_done;
  logic [CDB-1:0] exp_data;

  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hv0 <= 1'b0; hv1 <= 1'b0; hd0 <= '0; hd1 <= '0;
      exp_done <= 1'b0; exp_data <= '0;
    end else begin
      exp_done <= hv1;
      if (hv1) exp_data <= hd1;
      hv1 <= hv0;
      hd1 <= hd0;
      hv0 <= comp_init_i;
      hd0 <= ref_val(int'(comp_data_i), int'(comp_frac_i), comp_zero_i);
    end
  end

  always @(negedge clk_i) begin
    if (check_en) begin
      n_cmp++;
      if (comp_done_o !== exp_done || comp_data_o !== exp_data) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t: got done=%0b data=%h, want done=%0b data=%h",
                 $time, comp_done_o, comp_data_o, exp_done, exp_data);
      end
    end
  end

  task automatic chk(input string name, input logic [CDB-1:0] act, input logic [CDB-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit init, input bit z, input int e, input int f);
    comp_init_i = init;
    comp_zero_i = z;
    comp_data_i = EW'(e);
    comp_frac_i = FB'(f);
    @(negedge clk_i);
  endtask

  // Single pulse, then checks that the result appears exactly on the third cycle.
  task automatic pulse(input string name, input bit z, input int e, input int f,
                       input logic [CDB-1:0] want);
    drive(1'b1, z, e, f);
    drive(1'b0, 1'b0, 0, 0);
    chk({name, "_done_c2"}, CDB'(comp_done_o), CDB'(0));
    @(negedge clk_i);
    chk({name, "_done_c3"}, CDB'(comp_done_o), CDB'(1));
    chk({name, "_data"}, comp_data_o, want);
    @(negedge clk_i);
    chk({name, "_done_c4"}, CDB'(comp_done_o), CDB'(0));
    chk({name, "_hold"}, comp_data_o, want);
  endtask

  logic [CDB-1:0] held;

  initial begin
    repeat (3) @(negedge clk_i);
    chk("reset_done", CDB'(comp_done_o), CDB'(0));
    chk("reset_data", comp_data_o, CDB'(0));
    rst_n_i = 1'b1;
    check_en = 1'b1;
    @(negedge clk_i);

    pulse("e0_f0",   1'b0, 0, 0, CDB'(1));
    pulse("e10_f8",  1'b0, 10, 8, CDB'(1536));
    pulse("e2_f15",  1'b0, 2, 15, CDB'(7));
    pulse("e63_f15", 1'b0, 63, 15, 64'hF800_0000_0000_0000);
    pulse("zero",    1'b1, 40, 9, CDB'(0));
    pulse("e4_f3",   1'b0, 4, 3, CDB'(19));

    for (int i = 0; i < 64; i++) begin
      drive(1'b1, ($urandom_range(15) == 0), int'($urandom_range(63)), int'($urandom_range(15)));
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'(($urandom)), int'($urandom_range(63)), int'($urandom_range(15)));
    end
    held = comp_data_o;
    @(negedge clk_i);
    chk("gap_hold", comp_data_o, held);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, int'($urandom_range(63)), int'($urandom_range(15)));
    end
    drive(1'b0, 1'b0, 0, 0);
    repeat (4) @(negedge clk_i);

    drive(1'b1, 1'b0, 20, 5);
    drive(1'b1, 1'b0, 30, 7);
    comp_init_i = 1'b0;
    @(posedge clk_i);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("rst_async_done", CDB'(comp_done_o), CDB'(0));
    chk("rst_async_data", comp_data_o, CDB'(0));
    @(negedge clk_i);
    rst_n_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("post_rst_done", CDB'(comp_done_o), CDB'(0));
    end
    chk("post_rst_data", comp_data_o, CDB'(0));

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
